// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: segment patterns, the decoded-digit
// record and the dwell-FSM state type used by the scan reader.
package sevenseg_pkg;

  // Segment pattern, bit order {g,f,e,d,c,b,a}, active-high.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_BLANK = 7'h00;

  // Nibble reported for any pattern that is not a legal digit.
  localparam logic [3:0] NIB_ERR = 4'hF;

  // Result of decoding one segment pattern.
  typedef struct packed {
    logic       err;
    logic [3:0] nib;
  } dec_t;

  // Dwell FSM: SETTLE counts stable samples, HELD marks the dwell captured.
  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    HELD   = 1'b1
  } dwell_state_t;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational seven-segment pattern to BCD decoder. Illegal patterns
// report err=1 with nibble 4'hF so downstream checkers see a marker value.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  seg_t seg,
  output dec_t dec
);

  // Map each legal digit pattern to its value; everything else is an error.
  always_comb begin
    dec = '{err: 1'b0, nib: 4'h0};
    case (seg)
      SEG_0:   dec = '{err: 1'b0, nib: 4'd0};
      SEG_1:   dec = '{err: 1'b0, nib: 4'd1};
      SEG_2:   dec = '{err: 1'b0, nib: 4'd2};
      SEG_3:   dec = '{err: 1'b0, nib: 4'd3};
      SEG_4:   dec = '{err: 1'b0, nib: 4'd4};
      SEG_5:   dec = '{err: 1'b0, nib: 4'd5};
      SEG_6:   dec = '{err: 1'b0, nib: 4'd6};
      SEG_7:   dec = '{err: 1'b0, nib: 4'd7};
      SEG_8:   dec = '{err: 1'b0, nib: 4'd8};
      SEG_9:   dec = '{err: 1'b0, nib: 4'd9};
      default: dec = '{err: 1'b1, nib: NIB_ERR};
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_reader.sv
// Reads a time-multiplexed seven-segment bus back into BCD frames.
// Each digit dwell must be stable for STABLE_CYCLES samples before it is
// captured once; a frame is emitted when every digit has been captured.
module sevenseg_scan_reader
  import sevenseg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig_en,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);

  // True when exactly one enable bit is set.
  function automatic logic is_onehot(input logic [DIGITS-1:0] v);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < DIGITS; i++) begin
      ones += {31'd0, v[i]};
    end
    return (ones == 1);
  endfunction

  // Sample pair registers.
  seg_t                        seg_q, seg_d;
  logic [DIGITS-1:0]           dig_q, dig_d;

  // Dwell FSM and stability counter.
  dwell_state_t                state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // Per-digit capture slots and the set of digits captured this frame.
  logic [DIGITS-1:0][3:0]      slot_nib_q, slot_nib_d;
  logic [DIGITS-1:0]           slot_err_q, slot_err_d;
  logic [DIGITS-1:0]           seen_q, seen_d;

  // Output buffer.
  logic                        frame_valid_q, frame_valid_d;
  logic [4*DIGITS-1:0]         frame_data_q, frame_data_d;
  logic [DIGITS-1:0]           frame_err_q, frame_err_d;
  logic                        overrun_q, overrun_d;

  logic                        pair_change;
  logic                        pins_onehot;
  logic                        capture;
  logic                        complete;
  logic                        buf_free;
  logic [DIGITS-1:0]           seen_next;
  dec_t                        dec;

  // The pins equal the sample whenever no change is seen, so decoding the
  // pins gives the same value as decoding the held sample at capture time.
  sevenseg_pattern_decode u_decode (
    .seg (seg),
    .dec (dec)
  );

  // Dwell tracking: a changed pair restarts the count, a stable one-hot pair
  // advances it, and reaching the threshold captures once and parks in HELD.
  always_comb begin
    seg_d       = seg;
    dig_d       = dig_en;
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    pair_change = (seg != seg_q) || (dig_en != dig_q);
    pins_onehot = is_onehot(dig_en);
    if (pair_change) begin
      state_d = SETTLE;
      cnt_d   = pins_onehot ? CNT_ONE : '0;
    end else if (state_q == HELD) begin
      state_d = HELD;
      cnt_d   = cnt_q;
    end else if (pins_onehot) begin
      if (cnt_q >= CNT_LAST) begin
        capture = 1'b1;
        state_d = HELD;
        cnt_d   = CNT_FULL;
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Slot update: the captured digit overwrites its slot; completion clears seen.
  always_comb begin
    slot_nib_d = slot_nib_q;
    slot_err_d = slot_err_q;
    seen_next  = seen_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (capture && dig_en[i]) begin
        slot_nib_d[i] = dec.nib;
        slot_err_d[i] = dec.err;
        seen_next[i]  = 1'b1;
      end else begin
        seen_next[i]  = seen_q[i];
      end
    end
    complete = capture && (&seen_next);
    if (complete) begin
      seen_d = '0;
    end else begin
      seen_d = seen_next;
    end
  end

  // Output buffer: load a completed frame when free, otherwise flag overrun;
  // an accept drops valid unless a new frame lands in the same cycle.
  always_comb begin
    frame_data_d  = frame_data_q;
    frame_err_d   = frame_err_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = 1'b0;
    buf_free      = !frame_valid_q || frame_ready;
    if (complete && buf_free) begin
      frame_data_d  = slot_nib_d;
      frame_err_d   = slot_err_d;
      frame_valid_d = 1'b1;
    end else if (complete) begin
      overrun_d     = 1'b1;
      frame_valid_d = frame_valid_q;
    end else begin
      frame_valid_d = frame_valid_q && !frame_ready;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q         <= SEG_BLANK;
      dig_q         <= '0;
      state_q       <= SETTLE;
      cnt_q         <= '0;
      slot_nib_q    <= '0;
      slot_err_q    <= '0;
      seen_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      frame_err_q   <= '0;
      overrun_q     <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      dig_q         <= dig_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      slot_nib_q    <= slot_nib_d;
      slot_err_q    <= slot_err_d;
      seen_q        <= seen_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// Scoreboard bench for sevenseg_scan_reader. The driver applies one input
// set per cycle and runs a dwell/frame reference model; completed frames go
// into a queue that the negedge monitor drains on each accepted handshake.
module tb_sevenseg_scan_reader;

  localparam int D = 4;
  localparam int S = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      seg = 7'h00;
  logic [D-1:0]    dig_en = '0;
  logic            frame_ready = 1'b1;
  logic            frame_valid;
  logic [4*D-1:0]  frame_data;
  logic [D-1:0]    frame_err;
  logic            overrun;

  sevenseg_scan_reader #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dig_en      (dig_en),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [6:0]      pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [6:0]      prev_seg;
  logic [D-1:0]    prev_dig;
  int              run;
  bit              m_seen [D];
  logic [3:0]      m_nib [D];
  bit              m_err [D];
  bit              m_valid, m_ov, m_zero;
  logic [4*D-1:0]  q_data [$];
  logic [D-1:0]    q_err  [$];

  // Expectations for the state the monitor is about to observe.
  bit              cur_valid, cur_ov, cur_zero;
  bit              started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_ones(input logic [D-1:0] v);
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(v[i]);
    return c;
  endfunction

  // Model of one clock edge using the inputs just driven.
  task automatic model_step();
    bit freed;
    bit all_seen;
    int hit;
    cur_valid = m_valid;
    cur_ov    = m_ov;
    cur_zero  = m_zero;
    if (!rst_n) begin
      prev_seg = 7'h00; prev_dig = '0; run = 0;
      for (int i = 0; i < D; i++) begin m_seen[i] = 0; m_nib[i] = 4'h0; m_err[i] = 0; end
      m_valid = 0; m_ov = 0; m_zero = 1;
      q_data.delete(); q_err.delete();
      return;
    end
    m_zero = 0;
    m_ov   = 0;
    if (seg == prev_seg && dig_en == prev_dig) run = (run < 1000) ? run + 1 : run;
    else run = 1;
    prev_seg = seg; prev_dig = dig_en;
    freed = !m_valid || frame_ready;
    if (m_valid && frame_ready) m_valid = 0;
    if (count_ones(dig_en) == 1 && run == S) begin
      hit = -1;
      for (int v = 0; v < 10; v++) if (pat_tab[v] == seg) hit = v;
      for (int i = 0; i < D; i++) begin
        if (dig_en[i]) begin
          m_seen[i] = 1;
          m_err[i]  = (hit < 0);
          m_nib[i]  = (hit < 0) ? 4'hF : 4'(hit);
        end
      end
      all_seen = 1;
      for (int i = 0; i < D; i++) if (!m_seen[i]) all_seen = 0;
      if (all_seen) begin
        logic [4*D-1:0] fd;
        logic [D-1:0]   fe;
        for (int i = 0; i < D; i++) begin
          fd[4*i +: 4] = m_nib[i];
          fe[i]        = m_err[i];
          m_seen[i]    = 0;
        end
        if (freed) begin
          q_data.push_back(fd);
          q_err.push_back(fe);
          m_valid = 1;
        end else begin
          m_ov = 1;
        end
      end
    end
  endtask

  task automatic cyc(input logic [6:0] s, input logic [D-1:0] d, input logic r, input logic rn);
    @(posedge clk);
    #2;
    seg = s; dig_en = d; frame_ready = r; rst_n = rn;
    model_step();
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                      input logic [6:0] p3, input int dw, input logic r);
    logic [6:0] p [D];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int i = 0; i < D; i++)
      for (int c = 0; c < dw; c++) cyc(p[i], D'(1) << i, r, 1'b1);
  endtask

  task automatic idle(input int n, input logic r);
    for (int c = 0; c < n; c++) cyc(7'h00, '0, r, 1'b1);
  endtask

  // Monitor: per-cycle valid/overrun checks and queue-based frame checks.
  always @(negedge clk) begin
    if (started) begin
      chk("frame_valid", 32'(frame_valid), 32'(cur_valid));
      chk("overrun", 32'(overrun), 32'(cur_ov));
      if (cur_zero) begin
        chk("reset_data", 32'(frame_data), 32'h0);
        chk("reset_err", 32'(frame_err), 32'h0);
      end
      if (frame_valid) begin
        if (q_data.size() == 0) begin
          chk("unexpected_frame", 32'(frame_data), 32'hFFFF_FFFF);
        end else begin
          chk("frame_data", 32'(frame_data), 32'(q_data[0]));
          chk("frame_err", 32'(frame_err), 32'(q_err[0]));
          if (frame_ready && rst_n) begin
            void'(q_data.pop_front());
            void'(q_err.pop_front());
          end
        end
      end
    end
  end

  initial begin
    cyc(7'h00, '0, 1'b1, 1'b0);
    cyc(7'h00, '0, 1'b1, 1'b0);
    started = 1'b1;
    idle(3, 1'b1);

    // Clean scan: 4321.
    scan(7'h06, 7'h5B, 7'h4F, 7'h66, 4, 1'b1);
    idle(3, 1'b1);

    // Short dwell on digit 1, then rescan it with a 5: 4351.
    cyc(7'h06, 4'b0001, 1'b1, 1'b1); cyc(7'h06, 4'b0001, 1'b1, 1'b1);
    cyc(7'h06, 4'b0001, 1'b1, 1'b1); cyc(7'h06, 4'b0001, 1'b1, 1'b1);
    cyc(7'h5B, 4'b0010, 1'b1, 1'b1); cyc(7'h5B, 4'b0010, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) cyc(7'h4F, 4'b0100, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) cyc(7'h66, 4'b1000, 1'b1, 1'b1);
    idle(3, 1'b1);
    for (int c = 0; c < 3; c++) cyc(7'h6D, 4'b0010, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Illegal pattern on digit 2.
    scan(7'h3F, 7'h7F, 7'h01, 7'h07, 3, 1'b1);
    idle(3, 1'b1);

    // Back-pressure across two scans, then release.
    scan(7'h06, 7'h5B, 7'h4F, 7'h66, 4, 1'b0);
    scan(7'h7D, 7'h6F, 7'h3F, 7'h07, 4, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Non-one-hot enables and a long single dwell.
    for (int c = 0; c < 10; c++) cyc(7'h06, 4'b0011, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) cyc(7'h06, 4'b0000, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) cyc(7'h66, 4'b0001, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Reset after three captures; the fourth digit alone gives no frame.
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 4; c++) cyc(7'h4F, D'(1) << i, 1'b1, 1'b1);
    cyc(7'h4F, 4'b0100, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) cyc(7'h6F, 4'b1000, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Randomized scanning with random back-pressure.
    for (int n = 0; n < 400; n++) begin
      logic [6:0]   p;
      logic [D-1:0] d;
      int           dw;
      if ($urandom_range(0, 7) == 0) d = D'($urandom);
      else d = D'(1) << $urandom_range(0, D - 1);
      if ($urandom_range(0, 9) < 8) p = pat_tab[$urandom_range(0, 9)];
      else p = 7'($urandom);
      dw = $urandom_range(1, 5);
      for (int c = 0; c < dw; c++) cyc(p, d, 1'($urandom_range(0, 9) < 7), 1'b1);
    end
    idle(10, 1'b1);

    chk("queue_drained", 32'(q_data.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_reader.md
# sevenseg_scan_reader

Receive-side counterpart of the `sevenseg` digit encoder. The block watches a time-multiplexed multi-digit seven-segment bus: a shared segment bus plus one-hot digit enables. It waits for each digit's pattern to be stable, decodes the pattern back to a 4-bit BCD value, and assembles one complete frame holding every digit. Completed frames go out on a valid/ready handshake, for self-checking display paths and loopback test fixtures.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (≥1).
- `STABLE_CYCLES`, default 3: consecutive identical samples required before a digit is captured (≥2).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `seg`  in  7: segment bus, active-high, bit order {g,f,e,d,c,b,a}. Same encoding as the `sevenseg` output.
- `dig_en`  in  DIGITS: digit enables, active-high; legal only when exactly one bit is set.
- `frame_valid`  out  1: frame available.
- `frame_ready`  in  1: consumer accepts the frame.
- `frame_data`  out  4*DIGITS: BCD values; digit i occupies bits [4i+3:4i].
- `frame_err`  out  DIGITS: bit i set when digit i's captured pattern is not a legal 0–9 pattern. Its `frame_data` nibble is then 4'hF.
- `overrun`  out  1: one-cycle pulse when a completed frame is dropped.

## Operation
- Input stage: `seg` and `dig_en` are registered every cycle into a sample pair.
- Dwell FSM, two states:
  - SETTLE: counts cycles in which the sample pair equals the previous sample pair and `dig_en` is one-hot.
  - HELD: the current dwell has already been captured.
- Any change of the sample pair returns the FSM to SETTLE with count 1 (count 0 if `dig_en` is not one-hot).
- Count reaching `STABLE_CYCLES` triggers a capture and moves the FSM to HELD.
- HELD ignores the unchanged pair. There is exactly one capture per dwell, however long the dwell lasts.
- Non-one-hot `dig_en` (all-zero blanking or multiple bits) never captures.
- Capture writes the decoded nibble and error bit into slot i and sets `seen[i]`. A re-capture of an already-seen digit overwrites that slot (latest value wins).
- Decode table (pattern → value):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4
  - 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9
  - Any other pattern → err, nibble 4'hF.
- Frame completion happens when all `seen` bits are set, including the set made by the current capture.
  - If the output buffer is free (`frame_valid`=0, or `frame_valid`&&`frame_ready` in this cycle), the slots load into `frame_data`/`frame_err` and `frame_valid` is set.
  - Otherwise the frame is dropped and `overrun` pulses.
  - In both cases `seen` clears.
- Output handshake: `frame_data`/`frame_err` are held stable while `frame_valid`=1 && `frame_ready`=0. `frame_valid` clears after an accept, unless a new frame loads in the same cycle; then it stays high with the new data.

## Timing
- Reset values: `frame_valid`=0, `frame_data`=0, `frame_err`=0, `overrun`=0. On reset, `seen`=0, the sample pair is zero, and the FSM is in SETTLE with count 0.
- Reset mid-dwell or with a frame pending discards everything. No frame is emitted for pre-reset captures.
- Capture latency: if the pins hold a new pair from before edge k, the sample updates at edge k and capture occurs at edge k+STABLE_CYCLES-1.
- Frame latency: `frame_valid` rises at the edge of the completing capture, i.e. k+STABLE_CYCLES-1 for the last digit.
- Minimum legal dwell per digit: STABLE_CYCLES cycles at the pins. Shorter dwells are silently ignored.
- Throughput: at most one frame per DIGITS×STABLE_CYCLES cycles. No combinational path from `frame_ready` to `frame_valid`.

## Structure
- `sevenseg_pkg`:
  - `SEG_0`…`SEG_9`, `SEG_BLANK` (7'h00) constants, shared with `sevenseg`.
  - `typedef logic [6:0] seg_t`.
  - Dwell-FSM `enum {SETTLE, HELD}`.
- Sub-module `sevenseg_pattern_decode`: combinational seg_t → {err, nibble}. It is reusable by other checkers.
- Top level contains the sample registers, dwell FSM/counter, slot array, and output buffer.

## Test plan
- DIGITS=4, STABLE_CYCLES=3, `frame_ready`=1. Scan digits 0..3 with patterns 0x06,0x5B,0x4F,0x66, 4 cycles each → one frame, `frame_data`=16'h4321, `frame_err`=0, `frame_valid` high exactly 1 cycle.
- Same scan, but digit 1 dwells 2 cycles → no capture for digit 1, no frame. Rescan digit 1 with 0x6D for 3 cycles → frame 16'h4351.
- Digit 2 pattern 0x01 → `frame_err`=4'b0100 and nibble 2 = F.
- `frame_ready`=0 across two full scans → first frame held stable, `overrun` pulses once at second completion. Raise `frame_ready` → first frame accepted, `frame_valid` drops next cycle.
- `dig_en`=4'b0011 or 4'b0000 for 10 cycles → no capture. A single digit held 20 cycles → exactly one capture.
- Assert `rst_n`=0 for 1 cycle after capturing 3 digits → all outputs 0. Capturing only the 4th digit afterwards produces no frame.
